// File: rtl/matmul_loader_if.sv
// Host write port and element-stream bus between matmul_loader and its neighbours.
// master = host/multiplier side, slave = the loader itself.
interface matmul_loader_if #(
  parameter int unsigned DW = 8
);
  logic          wr_en;
  logic          wr_sel;
  logic [7:0]    wr_addr;
  logic [DW-1:0] wr_data;
  logic          start;
  logic          busy;
  logic          done;
  logic [7:0]    A_loc;
  logic [DW-1:0] A_val;
  logic [7:0]    B_loc;
  logic [DW-1:0] B_val;
  logic          stream_valid;

  modport master (
    output wr_en, wr_sel, wr_addr, wr_data, start,
    input  busy, done, A_loc, A_val, B_loc, B_val, stream_valid
  );

  modport slave (
    input  wr_en, wr_sel, wr_addr, wr_data, start,
    output busy, done, A_loc, A_val, B_loc, B_val, stream_valid
  );
endinterface

// File: rtl/matmul_loader.sv
// Element streamer for the NxN matrix multiplier: host-loaded A/B stores, streamed in lockstep.
// MATMUL_LOADER_STORE_CLEAR_EN: when defined, rst also zeroes both operand stores.
module matmul_loader #(
  parameter int unsigned N         = 3,
  parameter int unsigned DW        = 8,
  parameter int unsigned DRAIN_CYC = 2
) (
  input logic             clk,
  input logic             rst,
  matmul_loader_if.slave  bus
);

  localparam int unsigned NN = N * N;
  localparam int unsigned AW = (NN > 1) ? $clog2(NN) : 1;
  localparam int unsigned CW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [7:0]  LastIdx  = 8'(NN - 1);
  localparam logic [CW-1:0] LastCnt = CW'(DRAIN_CYC - 1);

  typedef enum logic [1:0] {StIdle, StStream, StDrain, StDone} state_e;

  state_e        state_q, state_d;
  logic [7:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          valid_q, valid_d;
  logic [7:0]    loc_q, loc_d;
  logic [DW-1:0] a_val_q, a_val_d;
  logic [DW-1:0] b_val_q, b_val_d;

  logic [DW-1:0] mem_a [NN];
  logic [DW-1:0] mem_b [NN];

  // A start in the same cycle wins over a write.
  logic wr_accept;
  assign wr_accept = (state_q == StIdle) && bus.wr_en && !bus.start &&
                     (32'(bus.wr_addr) < NN);

  always_ff @(posedge clk) begin
`ifdef MATMUL_LOADER_STORE_CLEAR_EN
    if (rst) begin
      for (int i = 0; i < NN; i++) begin
        mem_a[i] <= '0;
        mem_b[i] <= '0;
      end
    end else if (wr_accept) begin
      if (bus.wr_sel) mem_b[bus.wr_addr[AW-1:0]] <= bus.wr_data;
      else            mem_a[bus.wr_addr[AW-1:0]] <= bus.wr_data;
    end
`else
    if (wr_accept) begin
      if (bus.wr_sel) mem_b[bus.wr_addr[AW-1:0]] <= bus.wr_data;
      else            mem_a[bus.wr_addr[AW-1:0]] <= bus.wr_data;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    busy_d  = (state_q != StIdle);
    done_d  = (state_q == StDone);
    valid_d = 1'b0;
    loc_d   = 8'hFF;
    a_val_d = '0;
    b_val_d = '0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StStream;
          idx_d   = '0;
        end
      end
      StStream: begin
        valid_d = 1'b1;
        loc_d   = idx_q;
        a_val_d = mem_a[idx_q[AW-1:0]];
        b_val_d = mem_b[idx_q[AW-1:0]];
        idx_d   = idx_q + 8'd1;
        if (idx_q == LastIdx) begin
          state_d = StDrain;
          cnt_d   = '0;
        end
      end
      StDrain: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastCnt) state_d = StDone;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      loc_q   <= 8'hFF;
      a_val_q <= '0;
      b_val_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      loc_q   <= loc_d;
      a_val_q <= a_val_d;
      b_val_q <= b_val_d;
    end
  end

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.stream_valid = valid_q;
  assign bus.A_loc        = loc_q;
  assign bus.B_loc        = loc_q;
  assign bus.A_val        = a_val_q;
  assign bus.B_val        = b_val_q;

endmodule

// File: tb/tb_matmul_loader.sv
// Directed bench for matmul_loader (N=3, DW=8, DRAIN_CYC=2) with an element scoreboard.
module tb_matmul_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  matmul_loader_if #(.DW(8)) bus ();

  matmul_loader #(.N(3), .DW(8), .DRAIN_CYC(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int passes = 0;
  bit mon_en = 1'b0;

  logic [7:0]  ma [9];
  logic [7:0]  mb [9];
  logic [23:0] sb [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Scoreboard side: every valid element must match the next expected one.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.stream_valid === 1'b1) begin
        chk("sb_nonempty", (sb.size() != 0), 1);
        if (sb.size() != 0) begin
          logic [23:0] e;
          e = sb.pop_front();
          chk("A_loc", bus.A_loc, e[23:16]);
          chk("B_loc", bus.B_loc, e[23:16]);
          chk("A_val", bus.A_val, e[15:8]);
          chk("B_val", bus.B_val, e[7:0]);
        end
      end else begin
        chk("idle_A_loc", bus.A_loc, 8'hFF);
        chk("idle_B_loc", bus.B_loc, 8'hFF);
        chk("idle_A_val", bus.A_val, 0);
        chk("idle_B_val", bus.B_val, 0);
      end
    end
  end

  task automatic wr(input logic sel, input logic [7:0] addr, input logic [7:0] data);
    bus.wr_en   = 1'b1;
    bus.wr_sel  = sel;
    bus.wr_addr = addr;
    bus.wr_data = data;
    @(negedge clk);
    bus.wr_en = 1'b0;
    if (addr < 8'd9) begin
      if (sel) mb[addr] = data;
      else     ma[addr] = data;
    end
  endtask

  // Called at a negedge in IDLE. t = edge that samples start; checks follow edges t+1..t+last.
  task automatic run(input bit ws, input int rst_at, input int wr_at, input int restart_at,
                     input bit chain, input bit pre);
    int nvis;
    int last;
    nvis = (rst_at != 0 && rst_at - 1 < 9) ? rst_at - 1 : 9;
    last = chain ? 12 : 14;
    for (int k = 0; k < nvis; k++) sb.push_back({8'(k), ma[k], mb[k]});
    if (!pre) begin
      bus.start = 1'b1;
      if (ws) begin
        bus.wr_en   = 1'b1;
        bus.wr_sel  = 1'b0;
        bus.wr_addr = 8'd0;
        bus.wr_data = 8'hAA;
      end
    end
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    bus.wr_en = 1'b0;
    for (int j = 1; j <= last; j++) begin
      bit live;
      @(posedge clk);
      @(negedge clk);
      live = !(rst_at != 0 && j >= rst_at);
      chk($sformatf("valid@%0d", j), bus.stream_valid, live && j <= 9);
      chk($sformatf("busy@%0d", j), bus.busy, live && j <= 12);
      chk($sformatf("done@%0d", j), bus.done, live && j == 12);
      rst       = (rst_at != 0 && j + 1 == rst_at);
      bus.start = (restart_at != 0 && j + 1 == restart_at) || (chain && j == last);
      bus.wr_en = (wr_at != 0 && j + 1 == wr_at);
      if (bus.wr_en) begin
        bus.wr_sel  = 1'b0;
        bus.wr_addr = 8'd1;
        bus.wr_data = 8'h77;
      end
    end
    if (!chain) chk("sb_drained", sb.size(), 0);
  endtask

  initial begin
    bus.wr_en   = 1'b0;
    bus.wr_sel  = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.start   = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_valid", bus.stream_valid, 0);
    chk("rst_A_loc", bus.A_loc, 8'hFF);
    chk("rst_B_loc", bus.B_loc, 8'hFF);
    chk("rst_A_val", bus.A_val, 0);
    chk("rst_B_val", bus.B_val, 0);
    rst    = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 9; k++) begin
      wr(1'b0, 8'(k), 8'(k));
      wr(1'b1, 8'(k), 8'(k) + 8'h40);
    end
    run(0, 0, 0, 0, 0, 0);

    // Out-of-range writes are dropped.
    wr(1'b0, 8'd9, 8'h55);
    wr(1'b1, 8'd9, 8'h55);
    wr(1'b0, 8'hFF, 8'h55);
    run(0, 0, 0, 0, 0, 0);

    // Write during STREAM and restart during DRAIN are both ignored.
    run(0, 0, 3, 10, 0, 0);

    // Start and write in the same IDLE cycle: start wins, write dropped.
    run(1, 0, 0, 0, 0, 0);
    run(0, 0, 0, 0, 0, 0);

    // Reset during the 5th element.
    run(0, 6, 0, 0, 0, 0);
`ifdef MATMUL_LOADER_STORE_CLEAR_EN
    for (int k = 0; k < 9; k++) begin
      ma[k] = 8'h00;
      mb[k] = 8'h00;
    end
`endif
    run(0, 0, 0, 0, 0, 0);

    // Back-to-back: start in the cycle after done.
    run(0, 0, 0, 0, 1, 0);
    run(0, 0, 0, 0, 0, 1);

    repeat (2) @(negedge clk);
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
